// File: rtl/aibnd_dcc_dll_seq_pkg.sv
// Shared types and constants for the aibnd DCC/DLL power-up sequencer.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package aibnd_dcc_dll_seq_pkg;

  // The encoding is visible on seq_state, so CSR/debug software depends on these values.
  typedef enum logic [2:0] {
    ST_RST        = 3'd0,
    ST_DCC_CAL    = 3'd1,
    ST_DCC_SETTLE = 3'd2,
    ST_DLL_CAL    = 3'd3,
    ST_LOCKED     = 3'd4,
    ST_ERR        = 3'd5
  } seq_state_e;

  localparam int RST_CYC_DEF    = 16;
  localparam int DCC_TMO_DEF    = 4096;
  localparam int SETTLE_CYC_DEF = 64;
  localparam int DLL_TMO_DEF    = 8192;
  localparam int LOCK_FILT_DEF  = 8;
  localparam int MAX_RETRY_DEF  = 3;
  localparam int RETRY_W        = 2;

  // Width of a counter that counts 0 .. n-1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int RST_W    = cnt_w(RST_CYC_DEF);
  localparam int DCC_W    = cnt_w(DCC_TMO_DEF);
  localparam int SETTLE_W = cnt_w(SETTLE_CYC_DEF);
  localparam int DLL_W    = cnt_w(DLL_TMO_DEF);
  localparam int FILT_W   = cnt_w(LOCK_FILT_DEF);

endpackage

// File: rtl/aibnd_dcc_dll_seq_if.sv
// Control and status bundle between the core/CSR side and the DCC/DLL sequencer.
// Latency: none (wires only). Backpressure: none; all signals are levels.
// master = core/CSR side plus the analog status inputs, slave = sequencer.
interface aibnd_dcc_dll_seq_if;
  logic       seq_en;       // low forces and holds RST
  logic       reinit;       // level; forces RST, clears retries and error
  logic       rb_dcc_byp;   // skip the DCC phase
  logic       rb_cont_cal;  // LOCKED also watches dcc_done
  logic       dcc_done;     // asynchronous to clk_pll
  logic       dll_lock;     // asynchronous to clk_pll
  logic       dcc_rst_n;    // DCC reset, active-low
  logic       dll_rst_n;    // DLL phase-detector reset, active-low
  logic       cal_done;     // high only in LOCKED
  logic       cal_err;      // high only in ERR
  logic [1:0] retry_cnt;    // retries consumed, saturating
  logic [2:0] seq_state;    // encoded state

  modport master (
    output seq_en, reinit, rb_dcc_byp, rb_cont_cal, dcc_done, dll_lock,
    input  dcc_rst_n, dll_rst_n, cal_done, cal_err, retry_cnt, seq_state
  );

  modport slave (
    input  seq_en, reinit, rb_dcc_byp, rb_cont_cal, dcc_done, dll_lock,
    output dcc_rst_n, dll_rst_n, cal_done, cal_err, retry_cnt, seq_state
  );
endinterface

// File: rtl/aibnd_sync2.sv
// Two-flop synchronizer for a level crossing into the clk domain.
// Latency: 2 clk cycles. Backpressure: none.
// Ports: clk, rst_n (synchronous, active-low), d (async level in), q (synchronized out).
module aibnd_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/aibnd_dcc_dll_seq.sv
// DCC/DLL power-up and recalibration sequencer with timeouts, bounded retry and sticky error.
// Latency: async status inputs act 2 cycles after arrival; outputs are registered with the state.
// Backpressure: none; seq_en/reinit are levels and override any in-progress phase.
// Ports: clk_pll, nrst (synchronous, active-low), bus (aibnd_dcc_dll_seq_if.slave).
module aibnd_dcc_dll_seq
  import aibnd_dcc_dll_seq_pkg::*;
#(
  parameter int RST_CYC    = RST_CYC_DEF,
  parameter int DCC_TMO    = DCC_TMO_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int DLL_TMO    = DLL_TMO_DEF,
  parameter int LOCK_FILT  = LOCK_FILT_DEF,
  parameter int MAX_RETRY  = MAX_RETRY_DEF
) (
  input logic               clk_pll,
  input logic               nrst,
  aibnd_dcc_dll_seq_if.slave bus
);
  // One phase timer is shared by all states; it only ever runs in one phase at a time.
  localparam int TMR_W  = cnt_w(max_i(max_i(RST_CYC, DCC_TMO), max_i(SETTLE_CYC, DLL_TMO)));
  localparam int LFLT_W = cnt_w(LOCK_FILT);

  seq_state_e          state_q, state_nxt;
  logic [TMR_W-1:0]    tmr_q, tmr_nxt;
  logic [LFLT_W-1:0]   filt_q, filt_nxt;
  logic [RETRY_W-1:0]  retry_q, retry_nxt;
  logic                byp_q, byp_nxt;
  logic                retry_evt;
  logic                dcc_rst_n_q, dll_rst_n_q, cal_done_q, cal_err_q;
  logic                dcc_rst_n_nxt, dll_rst_n_nxt, cal_done_nxt, cal_err_nxt;
  logic                s_done, s_lock;

  aibnd_sync2 u_sync_done (.clk(clk_pll), .rst_n(nrst), .d(bus.dcc_done), .q(s_done));
  aibnd_sync2 u_sync_lock (.clk(clk_pll), .rst_n(nrst), .d(bus.dll_lock), .q(s_lock));

  always_ff @(posedge clk_pll) begin
    if (!nrst) begin
      state_q     <= ST_RST;
      tmr_q       <= '0;
      filt_q      <= '0;
      retry_q     <= '0;
      byp_q       <= 1'b0;
      dcc_rst_n_q <= 1'b0;
      dll_rst_n_q <= 1'b0;
      cal_done_q  <= 1'b0;
      cal_err_q   <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      tmr_q       <= tmr_nxt;
      filt_q      <= filt_nxt;
      retry_q     <= retry_nxt;
      byp_q       <= byp_nxt;
      dcc_rst_n_q <= dcc_rst_n_nxt;
      dll_rst_n_q <= dll_rst_n_nxt;
      cal_done_q  <= cal_done_nxt;
      cal_err_q   <= cal_err_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    tmr_nxt   = tmr_q + TMR_W'(1);
    filt_nxt  = '0;
    retry_nxt = retry_q;
    byp_nxt   = byp_q;
    retry_evt = 1'b0;

    if (bus.reinit) begin
      state_nxt = ST_RST;
      tmr_nxt   = '0;
      retry_nxt = '0;
    end else if (!bus.seq_en) begin
      state_nxt = ST_RST;
      tmr_nxt   = '0;
    end else begin
      unique case (state_q)
        ST_RST: begin
          if (tmr_q == TMR_W'(RST_CYC - 1)) begin
            // Bypass is captured here so it cannot change mid-calibration.
            byp_nxt   = bus.rb_dcc_byp;
            tmr_nxt   = '0;
            state_nxt = bus.rb_dcc_byp ? ST_DLL_CAL : ST_DCC_CAL;
          end
        end
        ST_DCC_CAL: begin
          if (s_done) begin
            state_nxt = ST_DCC_SETTLE;
            tmr_nxt   = '0;
          end else if (tmr_q == TMR_W'(DCC_TMO - 1)) begin
            retry_evt = 1'b1;
          end
        end
        ST_DCC_SETTLE: begin
          // A dropout restarts the DCC wait with a fresh timeout; it is not a failure.
          if (!s_done) begin
            state_nxt = ST_DCC_CAL;
            tmr_nxt   = '0;
          end else if (tmr_q == TMR_W'(SETTLE_CYC - 1)) begin
            state_nxt = ST_DLL_CAL;
            tmr_nxt   = '0;
          end
        end
        ST_DLL_CAL: begin
          if (s_lock) filt_nxt = filt_q + LFLT_W'(1);
          // Qualification is checked first so it wins a same-cycle timeout.
          if (s_lock && (filt_q == LFLT_W'(LOCK_FILT - 1))) begin
            state_nxt = ST_LOCKED;
            tmr_nxt   = '0;
            filt_nxt  = '0;
          end else if (tmr_q == TMR_W'(DLL_TMO - 1)) begin
            retry_evt = 1'b1;
          end
        end
        ST_LOCKED: begin
          tmr_nxt = '0;
          if (!s_lock || (bus.rb_cont_cal && !byp_q && !s_done)) retry_evt = 1'b1;
        end
        ST_ERR: begin
          tmr_nxt = '0;
        end
        default: begin
          state_nxt = ST_RST;
          tmr_nxt   = '0;
        end
      endcase

      if (retry_evt) begin
        tmr_nxt  = '0;
        filt_nxt = '0;
        if (retry_q == RETRY_W'(MAX_RETRY)) begin
          state_nxt = ST_ERR;
        end else begin
          retry_nxt = retry_q + RETRY_W'(1);
          state_nxt = ST_RST;
        end
      end
    end

    // Outputs are decoded from the next state so they register together with it.
    dll_rst_n_nxt = (state_nxt == ST_DLL_CAL) || (state_nxt == ST_LOCKED);
    dcc_rst_n_nxt = (state_nxt == ST_DCC_CAL) || (state_nxt == ST_DCC_SETTLE) ||
                    (dll_rst_n_nxt && !byp_nxt);
    cal_done_nxt  = (state_nxt == ST_LOCKED);
    cal_err_nxt   = (state_nxt == ST_ERR);
  end

  assign bus.dcc_rst_n = dcc_rst_n_q;
  assign bus.dll_rst_n = dll_rst_n_q;
  assign bus.cal_done  = cal_done_q;
  assign bus.cal_err   = cal_err_q;
  assign bus.retry_cnt = retry_q;
  assign bus.seq_state = state_q;
endmodule
